// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a linear beat command into INCR bursts (<=256 beats, never crossing 4KiB), one outstanding.
// R beats pass through with zero latency; out_ready drives rready directly, so the sink backpressures the slave.
module axi_burst_reader #(
  parameter int ADDR_WTH = 32,
  parameter int DATA_WTH = 256,
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_WTH-1:0] cmd_addr,
  input  logic [15:0]         cmd_beats,
  output logic [DATA_WTH-1:0] out_data,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done_valid,
  output logic                done_err,
  output logic [ADDR_WTH-1:0] araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [ID_WIDTH-1:0] arid,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_WTH-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic                rvalid,
  output logic                rready
);

  localparam int BEAT_BYTES = DATA_WTH / 8;
  localparam int LOG2B      = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WTH-1:0] araddr_q, araddr_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [8:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic                r_fire;
  logic                beat_err;
  logic [12:0]         bound_bytes;
  logic [12:0]         to_bound;
  logic [15:0]         plan_len;
  logic [ADDR_WTH-1:0] burst_bytes;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      araddr_q    <= '0;
      remaining_q <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      araddr_q    <= araddr_d;
      remaining_q <= remaining_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_PLAN;
      S_PLAN:  state_d = (remaining_q != 16'd0) ? S_AR : S_DONE;
      S_AR:    if (arready) state_d = S_R;
      S_R:     if (r_fire && rlast) state_d = S_PLAN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign r_fire = (state_q == S_R) && rvalid && out_ready;

  // Beat index (beats already taken this burst) must reach arlen exactly on rlast.
  assign beat_err = (rresp != 2'b00) || (rid != ID_WIDTH'(AXI_ID)) ||
                    (rlast && (beat_cnt_q != {1'b0, arlen_q})) ||
                    (!rlast && (beat_cnt_q > {1'b0, arlen_q}));

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    bound_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    to_bound    = bound_bytes >> LOG2B;
    plan_len    = remaining_q;
    if ({3'b000, to_bound} < plan_len) plan_len = {3'b000, to_bound};
    if (plan_len > 16'd256) plan_len = 16'd256;
    burst_bytes = ADDR_WTH'({1'b0, arlen_q} + 9'd1) << LOG2B;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr & ~ADDR_WTH'(BEAT_BYTES - 1);
          remaining_d = cmd_beats;
          err_d       = 1'b0;
        end
      end
      S_PLAN: begin
        if (remaining_q != 16'd0) begin
          araddr_d = cur_addr_q;
          arlen_d  = 8'(plan_len - 16'd1);
        end
      end
      S_AR: begin
        if (arready) begin
          cur_addr_d  = cur_addr_q + burst_bytes;
          remaining_d = remaining_q - (16'(arlen_q) + 16'd1);
          beat_cnt_d  = '0;
        end
      end
      S_R: begin
        if (r_fire) begin
          // Saturate so a runaway burst never wraps back into the legal range.
          if (beat_cnt_q != 9'h1FF) beat_cnt_d = beat_cnt_q + 9'd1;
          if (beat_err) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    arvalid    = (state_q == S_AR);
    rready     = (state_q == S_R) && out_ready;
    out_valid  = (state_q == S_R) && rvalid;
    out_data   = rdata;
    out_last   = out_valid && rlast && (remaining_q == 16'd0);
    done_valid = (state_q == S_DONE);
    done_err   = (state_q == S_DONE) && err_q;
    araddr     = araddr_q;
    arlen      = arlen_q;
  end

  assign arsize  = 3'(LOG2B);
  assign arburst = 2'b01;
  assign arid    = ID_WIDTH'(AXI_ID);

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader at 64-bit data: scripted AXI slave plus scoreboard queues for AR requests and output beats.
module tb_axi_burst_reader;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_beats;
  logic [DW-1:0] out_data;
  logic          out_last, out_valid, out_ready;
  logic          done_valid, done_err;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [IW-1:0] rid;
  logic          rvalid, rready;

  axi_burst_reader #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW), .AXI_ID(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done_valid(done_valid), .done_err(done_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [64:0] exp_beat_q[$];  // {last, data}
  logic [39:0] exp_ar_q[$];    // {araddr, arlen}
  int          burst_q[$];

  int          ar_delay = 0, ar_wait = 0, out_mode = 0, err_mode = 0;
  logic        busy = 1'b0;
  int          b_len = 0, b_idx = 0;
  logic [31:0] slave_seq = '0, exp_seq = '0;
  int          done_cnt = 0, done_cyc = 0, ar_hi_cnt = 0, beats_seen = 0, acc_cyc = 0;
  logic        last_done_err = 1'b0, prev_done = 1'b0;

  // Slave + monitor: observe at negedge (what the next posedge will see), drive just after posedge.
  initial begin : slave_monitor
    logic        ar_fire, r_fire;
    logic [7:0]  ar_len_cap;
    logic [64:0] e;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk_i);
      ar_fire    = arvalid && arready;
      r_fire     = rvalid && rready;
      ar_len_cap = arlen;
      if (!rst_i) begin
        if (arvalid) begin
          ar_hi_cnt++;
          n_vec++;
          if (exp_ar_q.size() == 0) begin
            n_err++;
            $display("FAIL ar_unexpected: got araddr=%h arlen=%0d, required no AR", araddr, arlen);
          end else if ({araddr, arlen} !== exp_ar_q[0] || arsize !== 3'd3 || arburst !== 2'b01 || arid !== 4'd0) begin
            n_err++;
            $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d, required addr=%h len=%0d size=3 burst=1 id=0",
                     araddr, arlen, arsize, arburst, arid, exp_ar_q[0][39:8], exp_ar_q[0][7:0]);
          end
          if (ar_fire && exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
        end
        if (rvalid) begin
          n_vec++;
          if (rready !== out_ready || out_valid !== 1'b1 || out_data !== rdata) begin
            n_err++;
            $display("FAIL r_passthru: got rready=%b out_valid=%b out_data=%h, required rready=%b out_valid=1 out_data=%h",
                     rready, out_valid, out_data, out_ready, rdata);
          end
        end
        if (out_valid && out_ready) begin
          n_vec++;
          beats_seen++;
          if (exp_beat_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_extra: got data=%h last=%b, required no beat", out_data, out_last);
          end else begin
            e = exp_beat_q.pop_front();
            if (out_data !== e[63:0] || out_last !== e[64]) begin
              n_err++;
              $display("FAIL beat: got data=%h last=%b, required data=%h last=%b", out_data, out_last, e[63:0], e[64]);
            end
          end
        end
        if (done_valid) begin
          n_vec++;
          if (prev_done) begin
            n_err++;
            $display("FAIL done_width: got done_valid high 2 cycles, required 1");
          end
          done_cnt++;
          done_cyc      = cyc;
          last_done_err = done_err;
        end
        prev_done = done_valid;
      end
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        busy = 1'b0; burst_q.delete(); arready = 1'b0; ar_wait = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0;
      end else begin
        if (ar_fire) burst_q.push_back(int'(ar_len_cap) + 1);
        if (r_fire) begin
          slave_seq++;
          if (rlast) busy = 1'b0;
          else b_idx++;
        end
        if (!busy && burst_q.size() != 0) begin
          b_len = burst_q.pop_front(); b_idx = 0; busy = 1'b1;
        end
        if (busy) begin
          rvalid = 1'b1;
          rdata  = {~slave_seq, slave_seq};
          rlast  = (b_idx == b_len - 1) || (err_mode == 3 && b_idx == 1);
          rresp  = (err_mode == 1 && b_idx == 1) ? 2'd2 : 2'd0;
          rid    = (err_mode == 2 && b_idx == 1) ? 4'd3 : 4'd0;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = '0; rid = '0;
        end
        if (arvalid) begin
          if (ar_wait >= ar_delay) arready = 1'b1;
          else begin arready = 1'b0; ar_wait++; end
        end else begin
          arready = 1'b0; ar_wait = 0;
        end
        out_ready = (out_mode == 1) ? ~out_ready : 1'b1;
      end
    end
  end

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_beat_q.push_back({(i == n - 1), ~exp_seq, exp_seq});
      exp_seq++;
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar_q.push_back({a, l});
  endtask

  task automatic issue_cmd(input logic [31:0] addr, input logic [15:0] beats, input string name);
    logic ok;
    ok = 1'b0;
    ar_hi_cnt = 0;
    @(posedge clk_i); #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = beats;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (cmd_ready) begin ok = 1'b1; acc_cyc = cyc; break; end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_accept: got cmd_ready=0 for 200 cycles, required 1", name);
    end
    @(posedge clk_i); #1;
    cmd_valid = 1'b0; cmd_addr = '1; cmd_beats = '1;
  endtask

  task automatic wait_done(input int prev, input logic exp_err, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_i);
      if (done_cnt != prev) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_done_timeout: got no done_valid in 2000 cycles, required one", name);
    end else if (last_done_err !== exp_err) begin
      n_err++;
      $display("FAIL %s_done_err: got %b, required %b", name, last_done_err, exp_err);
    end
    n_vec++;
    if (exp_beat_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: got %0d beats and %0d ARs outstanding, required 0 and 0", name, exp_beat_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] beats, input logic exp_err, input string name);
    int prev;
    prev = done_cnt;
    issue_cmd(addr, beats, name);
    wait_done(prev, exp_err, name);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    n_vec++;
    if ({arvalid, rready, out_valid, done_valid, done_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got arvalid/rready/out_valid/done_valid/done_err=%b, required 00000",
               {arvalid, rready, out_valid, done_valid, done_err});
    end
    n_vec++;
    if (araddr !== 32'h0 || arlen !== 8'h0) begin n_err++; $display("FAIL reset_ar: got araddr=%h arlen=%0d, required 0 0", araddr, arlen); end
    n_vec++;
    if (arsize !== 3'd3 || arburst !== 2'b01 || arid !== 4'd0) begin
      n_err++;
      $display("FAIL reset_consts: got arsize=%0d arburst=%0d arid=%0d, required 3 1 0", arsize, arburst, arid);
    end
    @(posedge clk_i); #2;
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    push_ar(32'h8000_0000, 8'd3);
    push_beats(4);
    run_cmd(32'h8000_0000, 16'd4, 1'b0, "single");
  endtask

  task automatic test_4k_split();
    push_ar(32'h8000_0FF0, 8'd1);
    push_ar(32'h8000_1000, 8'd1);
    push_beats(4);
    run_cmd(32'h8000_0FF5, 16'd4, 1'b0, "split4k");
  endtask

  task automatic test_long();
    push_ar(32'h8000_0000, 8'd255);
    push_ar(32'h8000_0800, 8'd43);
    push_beats(300);
    run_cmd(32'h8000_0000, 16'd300, 1'b0, "long");
  endtask

  task automatic test_backpressure();
    ar_delay = 5; out_mode = 1;
    push_ar(32'h8000_0100, 8'd5);
    push_beats(6);
    run_cmd(32'h8000_0100, 16'd6, 1'b0, "backpressure");
    n_vec++;
    if (ar_hi_cnt !== 6) begin n_err++; $display("FAIL backpressure_ar_cycles: got %0d, required 6", ar_hi_cnt); end
    ar_delay = 0; out_mode = 0;
  endtask

  task automatic test_errors();
    for (int m = 1; m <= 3; m++) begin
      err_mode = m;
      push_ar(32'h8000_0200, 8'd3);
      push_beats((m == 3) ? 2 : 4);
      run_cmd(32'h8000_0200, 16'd4, 1'b1, "err_inject");
      err_mode = 0;
      push_ar(32'h8000_0300, 8'd1);
      push_beats(2);
      run_cmd(32'h8000_0300, 16'd2, 1'b0, "err_clean");
    end
  endtask

  task automatic test_zero();
    run_cmd(32'h8000_0400, 16'd0, 1'b0, "zero");
    n_vec++;
    if (ar_hi_cnt !== 0) begin n_err++; $display("FAIL zero_ar: got %0d arvalid cycles, required 0", ar_hi_cnt); end
    n_vec++;
    if (done_cyc - acc_cyc !== 2) begin n_err++; $display("FAIL zero_latency: got %0d cycles, required 2", done_cyc - acc_cyc); end
  endtask

  task automatic test_reset_mid();
    int prev, base;
    logic ok;
    prev = done_cnt;
    push_ar(32'h8000_0000, 8'd15);
    push_beats(16);
    base = beats_seen;
    issue_cmd(32'h8000_0000, 16'd16, "reset_mid");
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      if (beats_seen - base >= 3) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_mid_beats: got %0d beats, required 3", beats_seen - base); end
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready !== 1'b1 || {arvalid, rready, out_valid, out_last, done_valid, done_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: got cmd_ready=%b arvalid/rready/out_valid/out_last/done_valid/done_err=%b, required 1 000000",
               cmd_ready, {arvalid, rready, out_valid, out_last, done_valid, done_err});
    end
    n_vec++;
    if (araddr !== 32'h0 || arlen !== 8'h0) begin n_err++; $display("FAIL reset_mid_ar: got araddr=%h arlen=%0d, required 0 0", araddr, arlen); end
    repeat (3) @(posedge clk_i);
    n_vec++;
    if (done_cnt !== prev) begin n_err++; $display("FAIL reset_mid_done: got %0d done pulses, required 0", done_cnt - prev); end
    #1;
    rst_i = 1'b0;
    exp_beat_q.delete();
    exp_ar_q.delete();
    @(posedge clk_i); #2;
    exp_seq = slave_seq;
    push_ar(32'h8000_0040, 8'd2);
    push_beats(3);
    run_cmd(32'h8000_0040, 16'd3, 1'b0, "after_reset");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion by 500000 time units, required finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single();
    test_4k_split();
    test_long();
    test_backpressure();
    test_errors();
    test_zero();
    test_reset_mid();
    repeat (5) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_reader.md
Name: axi_burst_reader

Overview:
AXI4 read initiator: accepts a linear read command (start address, beat count), splits it into INCR bursts that never cross a 4KiB boundary and never exceed 256 beats, and streams returned beats on a valid/ready output. It is the master-side counterpart of the bench AXI memory models and sits between DV/loader logic and any AXI4 slave. It keeps one burst outstanding at a time.

Parameters:
ADDR_WTH, 32, address width of command and AR channel
DATA_WTH, 256, data width in bits; beat bytes B = DATA_WTH/8 (power of two, >= 8)
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ID driven on arid and expected on rid

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_WTH  start byte address; low log2(B) bits ignored (treated as 0)
cmd_beats  in  16  number of beats to read; 0 is legal
out_data  out  DATA_WTH  read beat (registered-free pass-through of rdata)
out_last  out  1  final beat of the whole command
out_valid  out  1  beat valid
out_ready  in  1  sink ready
done_valid  out  1  one-cycle command-complete pulse
done_err  out  1  qualified by done_valid: any error seen during the command
araddr  out  ADDR_WTH  burst address
arlen  out  8  beats-1
arsize  out  3  constant log2(B)
arburst  out  2  constant 2'b01 (INCR)
arid  out  ID_WIDTH  constant AXI_ID
arvalid  out  1  AR request
arready  in  1  AR accept
rdata  in  DATA_WTH  read data
rresp  in  2  read response
rlast  in  1  last beat of burst
rid  in  ID_WIDTH  response ID
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE; arvalid, rready, out_valid, done_valid, done_err = 0; araddr, arlen, counters = 0. Reset mid-command aborts immediately; no done pulse. Slave must be reset alongside.
- States: IDLE -> (cmd_valid&&cmd_ready) -> PLAN; PLAN -> AR (remaining>0) or DONE (remaining==0); AR -> (arvalid&&arready) -> R; R -> (rvalid&&rready&&rlast) -> PLAN; DONE -> IDLE.
- Command capture: cur_addr = cmd_addr & ~(B-1); remaining = cmd_beats; err cleared.
- PLAN (1 cycle): to_bound = (4096 - cur_addr[11:0]) / B; len = min(remaining, to_bound, 256); araddr <= cur_addr; arlen <= len-1; arvalid <= 1 on entering AR.
- AR: arvalid held with araddr/arlen stable until arready; on handshake cur_addr += len*B, remaining -= len, beat counter = 0.
- R: rready = out_ready; out_valid = rvalid; out_data = rdata (combinational pass-through, zero latency). Each rvalid&&rready increments beat counter.
- out_last = out_valid && rlast && remaining==0 (remaining already decremented for current burst).
- Errors (sticky until next command): rresp != 0 on any beat; rid != AXI_ID; rlast at beat counter != arlen; beat counter > arlen without rlast. Beats are forwarded regardless; burst always ends on rlast.
- DONE: done_valid=1 for exactly one cycle with done_err = sticky err. cmd_beats=0: IDLE->PLAN->DONE, no AR, done two cycles after accept.
- cmd_ready=0 outside IDLE; new command accepted earliest the cycle after DONE.
- Arithmetic: remaining 16 bits, cur_addr wraps modulo 2^ADDR_WTH (no error).

Test Plan:
- DATA_WTH=256, cmd_addr=0x8000_0000, cmd_beats=4 -> one AR araddr=0x80000000 arlen=3 arsize=5 arburst=1; 4 out beats, out_last on 4th; done_err=0.
- cmd_addr=0x8000_0FC0, cmd_beats=4 -> AR 0x80000FC0 arlen=1, then AR 0x80001000 arlen=1; out_last only on beat 4.
- DATA_WTH=64, cmd_addr=0x8000_0000, cmd_beats=300 -> AR 0x80000000 arlen=255, AR 0x80000800 arlen=43; 300 beats in order.
- arready held low 5 cycles; out_ready toggling 1/0 -> araddr/arlen stable while arvalid; rready mirrors out_ready; no beat lost or duplicated.
- Slave returns rresp=2 on beat 2 (or rid=3, or rlast on beat 2 of 4) -> all beats forwarded, done_err=1; next clean command reports done_err=0.
- cmd_beats=0 -> no arvalid, done_valid pulse 2 cycles after accept, done_err=0; rst_i asserted during R -> next cycle IDLE, all outputs 0, cmd_ready=1.
